// File: rtl/accel_pkg.sv
// Shared definitions for the increment engine: FSM encoding, control-word
// byte layout, register-block base addresses and the run-length clamp.
package accel_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WAIT  = 2'd2,
        ST_WRITE = 2'd3
    } state_e;

    // Byte positions of the fields inside control word 0
    localparam int CTRL_START_BYTE   = 0;
    localparam int CTRL_MAX_CNT_BYTE = 1;
    localparam int CTRL_INCR_BYTE    = 2;

    // Register-block base addresses as seen by the host
    localparam logic [31:0] CTRL_BASE = 32'h0000_0000;
    localparam logic [31:0] STAT_BASE = 32'h0000_0004;
    localparam logic [31:0] DATA_BASE = 32'h0000_1000;

    // Requested word count limited to the memory depth
    function automatic logic [7:0] clamp_count(input logic [7:0] max_cnt, input int depth);
        if (int'(max_cnt) > depth) return 8'(depth);
        return max_cnt;
    endfunction

endpackage

// File: rtl/accel_byte_adder.sv
// Adds the same 8-bit increment to every byte of a word; each byte wraps
// independently, nothing carries into the neighbouring byte.
module accel_byte_adder #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [7:0]            incr_i,
    output logic [DATA_WIDTH-1:0] sum_o
);

    for (genvar j = 0; j < DATA_WIDTH / 8; j++) begin : g_byte
        assign sum_o[8*j +: 8] = a_i[8*j +: 8] + incr_i;
    end

endmodule

// File: rtl/accel_incr_engine.sv
// Read-modify-write engine: walks words 0..N-1 of the data memory, adding a
// per-byte increment to each. Three cycles per word (READ, WAIT, WRITE).
module accel_incr_engine
    import accel_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 256,
    parameter int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_i,
    input  logic [7:0]              max_cnt_i,
    input  logic [7:0]              incr_i,
    output logic                    start_clr_o,
    output logic                    busy_o,
    output logic                    done,
    output logic                    clamp_o,
    output logic [7:0]              proc_cnt_o,
    output logic                    mem_req_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic                    mem_we_o,
    output logic [DATA_WIDTH/8-1:0] mem_be_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

    state_e                  state_q;
    logic [7:0]              k_q, n_q, incr_q, proc_cnt_q;
    logic                    done_q, done_pend_q, clamp_q, start_clr_q;
    logic                    mem_req_q, mem_we_q;
    logic [DATA_WIDTH/8-1:0] mem_be_q;
    logic [ADDR_WIDTH-1:0]   mem_addr_q;
    logic [DATA_WIDTH-1:0]   mem_wdata_q;

    logic [7:0]              n_d;
    logic                    clamp_d, last_d;
    logic [DATA_WIDTH-1:0]   sum_d;

    assign n_d     = clamp_count(max_cnt_i, MEM_DEPTH);
    assign clamp_d = int'(max_cnt_i) > MEM_DEPTH;
    assign last_d  = (k_q == n_q - 8'd1);

    accel_byte_adder #(.DATA_WIDTH(DATA_WIDTH)) u_adder (
        .a_i    (mem_rdata_i),
        .incr_i (incr_q),
        .sum_o  (sum_d)
    );

    // FSM with registered outputs; memory strobes are loaded on the edge that
    // enters READ/WRITE so they line up with the state they belong to.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            k_q         <= '0;
            n_q         <= '0;
            incr_q      <= '0;
            proc_cnt_q  <= '0;
            done_q      <= 1'b0;
            done_pend_q <= 1'b0;
            clamp_q     <= 1'b0;
            start_clr_q <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            start_clr_q <= 1'b0;
            done_pend_q <= 1'b0;
            done_q      <= done_q | done_pend_q;  // done lags the run end by one cycle
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        start_clr_q <= 1'b1;
                        done_q      <= 1'b0;
                        proc_cnt_q  <= '0;
                        k_q         <= '0;
                        n_q         <= n_d;
                        incr_q      <= incr_i;
                        clamp_q     <= clamp_d;
                        if (n_d != 8'd0) begin
                            state_q    <= ST_READ;
                            mem_req_q  <= 1'b1;
                            mem_addr_q <= '0;
                        end else begin
                            done_pend_q <= 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    state_q     <= ST_WRITE;
                    mem_req_q   <= 1'b1;
                    mem_we_q    <= 1'b1;
                    mem_be_q    <= '1;
                    mem_addr_q  <= ADDR_WIDTH'(k_q);
                    mem_wdata_q <= sum_d;
                end
                ST_WRITE: begin
                    proc_cnt_q <= proc_cnt_q + 8'd1;
                    if (last_d) begin
                        state_q     <= ST_IDLE;
                        done_pend_q <= 1'b1;
                    end else begin
                        state_q    <= ST_READ;
                        k_q        <= k_q + 8'd1;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= ADDR_WIDTH'(k_q + 8'd1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy_o      = (state_q != ST_IDLE);
    assign start_clr_o = start_clr_q;
    assign done        = done_q;
    assign clamp_o     = clamp_q;
    assign proc_cnt_o  = proc_cnt_q;
    assign mem_req_o   = mem_req_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_we_o    = mem_we_q;
    assign mem_be_o    = mem_be_q;
    assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_accel_incr_engine.sv
// Bench for accel_incr_engine: a 256-deep instance for most runs and a
// 16-deep instance for the clamp case, each with its own memory model.
module tb_accel_incr_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, start_i;
    logic [7:0] max_cnt_i, incr_i;

    logic        a_clr, a_busy, a_done, a_clamp, a_req, a_we;
    logic [7:0]  a_pcnt, a_addr;
    logic [3:0]  a_be;
    logic [31:0] a_wdata, a_rdata;
    logic        b_clr, b_busy, b_done, b_clamp, b_req, b_we;
    logic [7:0]  b_pcnt;
    logic [3:0]  b_addr, b_be;
    logic [31:0] b_wdata, b_rdata;

    accel_incr_engine #(.DATA_WIDTH(32), .MEM_DEPTH(256)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .max_cnt_i(max_cnt_i), .incr_i(incr_i),
        .start_clr_o(a_clr), .busy_o(a_busy), .done(a_done), .clamp_o(a_clamp),
        .proc_cnt_o(a_pcnt), .mem_req_o(a_req), .mem_addr_o(a_addr), .mem_we_o(a_we),
        .mem_be_o(a_be), .mem_wdata_o(a_wdata), .mem_rdata_i(a_rdata)
    );

    accel_incr_engine #(.DATA_WIDTH(32), .MEM_DEPTH(16)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .max_cnt_i(max_cnt_i), .incr_i(incr_i),
        .start_clr_o(b_clr), .busy_o(b_busy), .done(b_done), .clamp_o(b_clamp),
        .proc_cnt_o(b_pcnt), .mem_req_o(b_req), .mem_addr_o(b_addr), .mem_we_o(b_we),
        .mem_be_o(b_be), .mem_wdata_o(b_wdata), .mem_rdata_i(b_rdata)
    );

    // Memory models: one-cycle read latency, byte-enabled writes, plus a
    // bench-side preload port.
    logic        pre_we, pre_sel;
    logic [7:0]  pre_addr;
    logic [31:0] pre_data;
    logic [31:0] mem_a [256];
    logic [31:0] mem_b [16];

    always @(posedge clk) begin
        if (pre_we && !pre_sel) mem_a[pre_addr] <= pre_data;
        else if (a_req) begin
            if (a_we) begin
                for (int b = 0; b < 4; b++) if (a_be[b]) mem_a[a_addr][8*b +: 8] <= a_wdata[8*b +: 8];
            end else a_rdata <= mem_a[a_addr];
        end
        if (pre_we && pre_sel) mem_b[pre_addr[3:0]] <= pre_data;
        else if (b_req) begin
            if (b_we) begin
                for (int b = 0; b < 4; b++) if (b_be[b]) mem_b[b_addr][8*b +: 8] <= b_wdata[8*b +: 8];
            end else b_rdata <= mem_b[b_addr];
        end
    end

    // Observed view of whichever instance the current run targets
    logic        sel;
    logic        o_clr, o_busy, o_done, o_clamp, o_req, o_we;
    logic [7:0]  o_pcnt, o_addr;
    logic [3:0]  o_be;
    logic [31:0] o_wdata;
    always_comb begin
        o_clr   = sel ? b_clr   : a_clr;
        o_busy  = sel ? b_busy  : a_busy;
        o_done  = sel ? b_done  : a_done;
        o_clamp = sel ? b_clamp : a_clamp;
        o_req   = sel ? b_req   : a_req;
        o_we    = sel ? b_we    : a_we;
        o_pcnt  = sel ? b_pcnt  : a_pcnt;
        o_addr  = sel ? {4'b0, b_addr} : a_addr;
        o_be    = sel ? b_be    : a_be;
        o_wdata = sel ? b_wdata : a_wdata;
    end

    int checks   = 0;
    int failures = 0;
    int cur_vec  = -1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s vec=%0d actual=%0h expected=%0h", name, cur_vec, act, exp);
        end
    endtask

    function automatic logic [31:0] add_bytes(input logic [31:0] w, input logic [7:0] inc);
        logic [31:0] r;
        for (int j = 0; j < 4; j++) r[8*j +: 8] = w[8*j +: 8] + inc;
        return r;
    endfunction

    // mode: 0 = bytes 4i..4i+3, 1 = as 0 but word0 = 0x00FFFF7F, 2 = random
    typedef struct {
        int mode; int max_cnt; int incr; int exp_done; bit exp_clamp;
        int writes; int reqs; int restart_cyc; int reset_cyc; bit sel;
    } vec_t;

    task automatic run_vec(input int id, input vec_t v);
        int depth, first_done, reqs, busy_bad, lim, busy_end, bad_words;
        logic [31:0] pre [256];
        logic [31:0] exp_mem [256];
        logic [39:0] sbq [$];
        logic [39:0] ent;
        cur_vec = id;
        sel     = v.sel;
        depth   = v.sel ? 16 : 256;
        // preload
        for (int i = 0; i < depth; i++) begin
            logic [31:0] w;
            w = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
            if (v.mode == 1 && i == 0) w = 32'h00FF_FF7F;
            if (v.mode == 2) w = $urandom;
            pre[i] = w;
            pre_sel = v.sel; pre_addr = 8'(i); pre_data = w; pre_we = 1'b1;
            @(negedge clk);
        end
        pre_we = 1'b0;
        // expected results queued as the stimulus goes in
        for (int i = 0; i < depth; i++) exp_mem[i] = pre[i];
        for (int i = 0; i < v.writes; i++) begin
            exp_mem[i] = add_bytes(pre[i], 8'(v.incr));
            sbq.push_back({8'(i), exp_mem[i]});
        end
        first_done = -1; reqs = 0; busy_bad = 0;
        busy_end = (v.reset_cyc >= 0) ? v.reset_cyc : 3 * v.writes;
        lim      = (v.exp_done >= 0) ? v.exp_done + 3 : v.reset_cyc + 20;
        max_cnt_i = 8'(v.max_cnt); incr_i = 8'(v.incr); start_i = 1'b1;
        for (int c = 0; c <= lim; c++) begin
            @(posedge clk); @(negedge clk);
            if (c == 0) check("start_clr_pulse", 64'(o_clr), 64'd1);
            if (c == 1) check("start_clr_one_cycle", 64'(o_clr), 64'd0);
            if (v.restart_cyc >= 0 && c == v.restart_cyc) check("restart_ignored", 64'(o_clr), 64'd0);
            if (v.reset_cyc >= 0 && c == v.reset_cyc)
                check("reset_outputs", {o_clr, o_busy, o_done, o_clamp, o_pcnt, o_req, o_addr, o_we, o_be, o_wdata}, 64'd0);
            if (o_done && first_done < 0) first_done = c;
            if (o_busy != (c < busy_end)) busy_bad++;
            if (o_req) begin
                reqs++;
                if (o_we) begin
                    if (sbq.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_write vec=%0d cycle=%0d addr=%0h", id, c, o_addr);
                    end else begin
                        ent = sbq.pop_front();
                        check("wr_addr", 64'(o_addr), 64'(ent[39:32]));
                        check("wr_data", 64'(o_wdata), 64'(ent[31:0]));
                        check("wr_be", 64'(o_be), 64'hF);
                    end
                end
            end
            start_i = (v.restart_cyc >= 0 && c == v.restart_cyc - 1);
            if (v.restart_cyc >= 0 && c == v.restart_cyc - 1) begin
                max_cnt_i = 8'd2; incr_i = 8'h09;
            end
            rst_n = !(v.reset_cyc >= 0 && c == v.reset_cyc - 1);
        end
        check("done_cycle", 64'(first_done), 64'(v.exp_done));
        check("proc_cnt", 64'(o_pcnt), (v.reset_cyc >= 0) ? 64'd0 : 64'(v.writes));
        check("clamp", 64'(o_clamp), 64'(v.exp_clamp));
        check("busy_trace_errors", 64'(busy_bad), 64'd0);
        check("req_count", 64'(reqs), 64'(v.reqs));
        check("scoreboard_left", 64'(sbq.size()), 64'd0);
        bad_words = 0;
        for (int i = 0; i < depth; i++)
            if ((v.sel ? mem_b[i] : mem_a[i]) !== exp_mem[i]) bad_words++;
        check("mem_image_errors", 64'(bad_words), 64'd0);
        if (v.mode == 1) check("word0_value", 64'(mem_a[0]), 64'h8180_8000);
    endtask

    vec_t vt [8];

    initial begin
        //         mode max  incr  done clamp wr  reqs rstrt rst  sel
        vt[0] = '{0,   64,   1,    193, 1'b0, 64, 128, -1,   -1,  1'b0};
        vt[1] = '{1,   1,    8'h81,  4, 1'b0, 1,  2,   -1,   -1,  1'b0};
        vt[2] = '{0,   0,    5,      1, 1'b0, 0,  0,   -1,   -1,  1'b0};
        vt[3] = '{2,   5,    8'hFF, 16, 1'b0, 5,  10,  -1,   -1,  1'b0};
        vt[4] = '{2,   64,   3,    193, 1'b0, 64, 128, 10,   -1,  1'b0};
        vt[5] = '{0,   64,   1,     -1, 1'b0, 16, 33,  -1,   50,  1'b0};
        vt[6] = '{2,   255,  8'h7F, 766, 1'b0, 255, 510, -1,  -1,  1'b0};
        vt[7] = '{2,   20,   8'h11,  49, 1'b1, 16, 32,  -1,   -1,  1'b1};

        sel = 1'b0; rst_n = 1'b0; start_i = 1'b0; max_cnt_i = 8'd0; incr_i = 8'd0;
        pre_we = 1'b0; pre_sel = 1'b0; pre_addr = 8'd0; pre_data = 32'd0;
        repeat (3) @(negedge clk);
        check("reset_state_a", {a_clr, a_busy, a_done, a_clamp, a_pcnt, a_req, a_addr, a_we, a_be, a_wdata}, 64'd0);
        check("reset_state_b", {b_clr, b_busy, b_done, b_clamp, b_pcnt, b_req, b_we, b_be}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_reset", {a_busy, a_done, a_req}, 64'd0);

        for (int i = 0; i < 8; i++) run_vec(i, vt[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/accel_incr_engine.md
ACCEL_INCR_ENGINE -- requirements
Module: accel_incr_engine

Interface
REQ-001 Parameter: DATA_WIDTH, default 32, data word width in bits (multiple of 8).
REQ-002 Parameter: MEM_DEPTH, default 256, data memory depth in words.
REQ-003 Parameter: ADDR_WIDTH, default $clog2(MEM_DEPTH), data memory word-address width.
REQ-004 Port: clk  in  1  system clock; all logic on rising edge.
REQ-005 Port: rst_n  in  1  reset; synchronous and active-low.
REQ-006 Port: start_i  in  1  start request (ctrl word 0, byte 0, bit 0).
REQ-007 Port: max_cnt_i  in  8  number of words to process (ctrl word 0, byte 1).
REQ-008 Port: incr_i  in  8  per-byte increment (ctrl word 0, byte 2).
REQ-009 Port: start_clr_o  in/out  out 1  one-cycle pulse clearing the start bit in the ctrl register.
REQ-010 Port: busy_o  out  1  run in progress.
REQ-011 Port: done  out  1  run complete; held until next accepted start.
REQ-012 Port: clamp_o  out  1  max_cnt_i exceeded MEM_DEPTH on last start.
REQ-013 Port: proc_cnt_o  out  8  words written in current/last run.
REQ-014 Port: mem_req_o  out  1  data memory request.
REQ-015 Port: mem_addr_o  out  ADDR_WIDTH  data memory word address.
REQ-016 Port: mem_we_o  out  1  write enable (0 = read).
REQ-017 Port: mem_be_o  out  DATA_WIDTH/8  byte enables.
REQ-018 Port: mem_wdata_o  out  DATA_WIDTH  write data.
REQ-019 Port: mem_rdata_i  in  DATA_WIDTH  read data, valid the cycle after a read request.

Function
REQ-020 FSM states SHALL be IDLE, READ, WAIT, WRITE; N = min(max_cnt_i, MEM_DEPTH) latched at accepted start, with incr_i.
REQ-021 IDLE with start_i=1 SHALL accept start: pulse start_clr_o, clear done, proc_cnt_o=0, address counter k=0, set clamp_o if max_cnt_i>MEM_DEPTH; go READ if N>0, else set done next cycle and stay IDLE.
REQ-022 READ: mem_req_o=1, mem_we_o=0, mem_be_o=0, mem_addr_o=k; next state WAIT.
REQ-023 WAIT: no request; capture mem_rdata_i; next state WRITE.
REQ-024 WRITE: mem_req_o=1, mem_we_o=1, mem_be_o all ones, mem_addr_o=k, each byte j of mem_wdata_o = (captured byte j + incr) mod 256, no carry between bytes; proc_cnt_o increments.
REQ-025 After WRITE: if k=N-1 go IDLE and set done the following cycle, else k+1 and go READ; each word takes exactly 3 cycles.
REQ-026 With start sampled at edge 0, done SHALL be high from cycle 3N+1; busy_o high exactly while state is not IDLE.
REQ-027 start_i while busy_o=1 SHALL be ignored (no start_clr_o, no latch update).
REQ-028 Outside READ/WRITE: mem_req_o=0, mem_we_o=0, mem_be_o=0, mem_wdata_o=0.

Reset
REQ-029 rst_n=0 at a rising edge SHALL force IDLE, k=0, done=0, busy_o=0, clamp_o=0, proc_cnt_o=0, start_clr_o=0, all mem_* outputs 0.
REQ-030 Reset mid-run SHALL abort immediately; no further memory request until a new start after reset release.

Structure
REQ-031 Shared package accel_pkg SHALL hold the FSM state enum, ctrl-word byte offsets (START=0, MAX_CNT=1, INCR=2) and the CTRL/STAT/DATA base-address constants.
REQ-032 One sub-module accel_byte_adder (combinational per-byte modular add, DATA_WIDTH parameter) SHALL be instantiated; all else in accel_incr_engine.

Verification
REQ-033 Memory word i preloaded with bytes 4i..4i+3, max_cnt=64, incr=1, start -> each byte +1, done high at cycle 193, proc_cnt_o=64, clamp_o=0.
REQ-034 Word 0x00FF_FF7F, max_cnt=1, incr=0x81 -> written 0x8180_8000, done at cycle 4.
REQ-035 max_cnt=0, start -> no mem_req_o, done high at cycle 1, proc_cnt_o=0.
REQ-036 start pulsed again at cycle 10 of a 64-word run -> no start_clr_o, run completes unchanged at cycle 193.
REQ-037 rst_n=0 at cycle 50 of a run -> next cycle all outputs 0, state IDLE; words beyond k unmodified.
REQ-038 MEM_DEPTH=16, max_cnt=20 -> clamp_o=1, 16 words written, done at cycle 49.
